// File: rtl/rv32_alu_md.sv
// rv32_alu_md: RV32 base ALU plus the RV32M multiply/divide family.
// Base ops and divide special cases finish in one cycle; MUL*/DIV*/REM* run on a
// shared shift/add-subtract datapath, one step per cycle for XLEN cycles.
// Handshake: a request is taken on a rising edge where in_valid && in_ready; a result
// is taken on a rising edge where out_valid && out_ready; res/res_tag hold otherwise.
`ifndef RV32_ALU_MD_OPCODES
`define RV32_ALU_MD_OPCODES
`define ALU_OPCODE_WIDTH 5
`define ALU_ADD    5'd0
`define ALU_SUB    5'd1
`define ALU_SLL    5'd2
`define ALU_SLT    5'd3
`define ALU_SLTU   5'd4
`define ALU_XOR    5'd5
`define ALU_SRL    5'd6
`define ALU_SRA    5'd7
`define ALU_OR     5'd8
`define ALU_AND    5'd9
`define ALU_MUL    5'd10
`define ALU_MULH   5'd11
`define ALU_MULHSU 5'd12
`define ALU_MULHU  5'd13
`define ALU_DIV    5'd14
`define ALU_DIVU   5'd15
`define ALU_REM    5'd16
`define ALU_REMU   5'd17
`endif

module rv32_alu_md #(
    parameter int XLEN = 32,
    parameter int OPW  = `ALU_OPCODE_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      tag,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res,
    output logic [4:0]      res_tag,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, HOLD} state_t;
    state_t state, state_nxt;

    logic [SHW-1:0]    cnt;
    logic [2*XLEN-1:0] acc;       // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
    logic [XLEN-1:0]   opnd;      // multiplicand or divisor magnitude
    logic              neg;       // negate the final result
    logic              sel_hi;    // take the upper half of acc
    logic [4:0]        pend_tag;

    logic accept, is_mul, is_div, is_rem, sgn1, sgn2, neg1, neg2;
    logic div_zero, div_ovf, div_special, last_step;
    logic [XLEN-1:0]   mag1, mag2, base_res, quick_res, div_sel, iter_res;
    logic [SHW-1:0]    shamt;
    logic [XLEN:0]     mul_sum, rem_sh, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, mul_prod, step_next;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
    assign busy     = (state == MUL) || (state == DIV);
    assign accept   = in_valid && in_ready;

    // Classify the opcode and the signedness of each operand.
    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        is_rem = 1'b0;
        sgn1   = 1'b0;
        sgn2   = 1'b0;
        case (op)
            `ALU_MUL, `ALU_MULHU: is_mul = 1'b1;
            `ALU_MULH:   begin is_mul = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
            `ALU_MULHSU: begin is_mul = 1'b1; sgn1 = 1'b1; end
            `ALU_DIV:    begin is_div = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
            `ALU_DIVU:   is_div = 1'b1;
            `ALU_REM:    begin is_div = 1'b1; is_rem = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
            `ALU_REMU:   begin is_div = 1'b1; is_rem = 1'b1; end
            default: ;
        endcase
    end

    assign neg1        = sgn1 & rs1[XLEN-1];
    assign neg2        = sgn2 & rs2[XLEN-1];
    assign mag1        = neg1 ? -rs1 : rs1;
    assign mag2        = neg2 ? -rs2 : rs2;
    assign div_zero    = (rs2 == '0);
    assign div_ovf     = sgn1 && (rs1 == MIN_NEG) && (&rs2);
    assign div_special = is_div && (div_zero || div_ovf);
    assign quick_res   = div_zero ? (is_rem ? rs1 : '1) : (is_rem ? '0 : rs1);
    assign shamt       = rs2[SHW-1:0];

    // Single-cycle base ALU result.
    always_comb begin
        base_res = '0;
        case (op)
            `ALU_ADD:  base_res = rs1 + rs2;
            `ALU_SUB:  base_res = rs1 - rs2;
            `ALU_SLL:  base_res = rs1 << shamt;
            `ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(rs2)};
            `ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, rs1 < rs2};
            `ALU_XOR:  base_res = rs1 ^ rs2;
            `ALU_SRL:  base_res = rs1 >> shamt;
            `ALU_SRA:  base_res = $unsigned($signed(rs1) >>> shamt);
            `ALU_OR:   base_res = rs1 | rs2;
            `ALU_AND:  base_res = rs1 & rs2;
            default:   base_res = '0;
        endcase
    end

    // One shift-add (multiply) or restoring-subtract (divide) step, plus final sign fix-up.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        mul_prod  = neg ? -mul_next : mul_next;
        rem_sh    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = rem_sh - {1'b0, opnd};
        div_next  = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        div_sel   = sel_hi ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
        step_next = (state == DIV) ? div_next : mul_next;
        if (state == DIV) iter_res = neg ? -div_sel : div_sel;
        else              iter_res = sel_hi ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
    end

    assign last_step = (cnt == SHW'(XLEN-1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && is_mul)                     state_nxt = MUL;
                else if (accept && is_div && !div_special) state_nxt = DIV;
            end
            MUL, DIV: if (last_step) state_nxt = HOLD;
            HOLD:     if (out_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Operand capture, iteration datapath and the single-entry output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            res       <= '0;
            res_tag   <= '0;
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            neg       <= 1'b0;
            sel_hi    <= 1'b0;
            pend_tag  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt      <= '0;
                        pend_tag <= tag;
                        if (is_mul) begin
                            acc       <= {{XLEN{1'b0}}, mag2};
                            opnd      <= mag1;
                            neg       <= neg1 ^ neg2;
                            sel_hi    <= (op != `ALU_MUL);
                            out_valid <= 1'b0;
                        end else if (is_div && !div_special) begin
                            acc       <= {{XLEN{1'b0}}, mag1};
                            opnd      <= mag2;
                            neg       <= is_rem ? neg1 : (neg1 ^ neg2);
                            sel_hi    <= is_rem;
                            out_valid <= 1'b0;
                        end else begin
                            res       <= is_div ? quick_res : base_res;
                            res_tag   <= tag;
                            out_valid <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                MUL, DIV: begin
                    acc <= step_next;
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        res       <= iter_res;
                        res_tag   <= pend_tag;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                    end
                end
                HOLD: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
